uart_rx_oversample: RTL

// - Receive end of the 8N1-style UART link. Receives the serial frames that the team's UART transmitter sends.
// - Synchronises rxd, oversamples each bit, and majority-votes the samples to recover each data word.
// - Buffers recovered words in a small FIFO, presented on a valid/ready stream to the word-join logic.
// - Reports framing, overrun and (optionally) parity errors as single-cycle pulses.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_oversample_if.sv | 11 +
 rtl/uart_rx_fifo.sv | 43 ++++
 rtl/uart_rx_oversample.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    function automatic int tick_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Received-word stream: the receiver drives data/valid, the consumer drives ready.
interface uart_rx_oversample_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO; extra pointer MSB tells full from empty.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A write into a full FIFO is allowed when the head is leaving in the same clk.
    assign wr_en      = push_i && (!full_o || pop_i);
    assign rd_en      = pop_i && !empty_o;
    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_en};
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end
endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver with majority vote and receive FIFO.
// Parity bit support is enabled by defining UART_RX_PARITY_EN.
//   state  | meaning
//   IDLE   | line idle, waiting for rxs low
//   START  | checking start bit, false starts return to IDLE
//   DATA   | shifting in data bits LSB first
//   PARITY | even parity bit (UART_RX_PARITY_EN only)
//   STOP   | stop bit decided at s = M+1
//   BREAK  | stop bit was low; wait for line high
module uart_rx_oversample
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 200_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    uart_rx_oversample_if.master rx_if,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int M        = OVERSAMPLE / 2;

    localparam logic [TW-1:0] TICK_LD  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LO     = SW'(M - 1);
    localparam logic [SW-1:0] S_MID    = SW'(M);
    localparam logic [SW-1:0] S_HI     = SW'(M + 1);
    localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    if (TICK_DIV < 2) begin : g_tick_div_check
        $error("uart_rx_oversample: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
    end

    logic [1:0]            sync_q;
    logic                  rxs;
    rx_state_t             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [SW-1:0]         s_q, s_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  tick, at_dec, at_end, vote;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
`ifdef UART_RX_PARITY_EN
    logic                  par_q, par_d;
    logic                  parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rxd};
    end
    assign rxs = sync_q[1];

    // Tick is the terminal count of the prescaler; s counts ticks within a bit.
    assign tick   = (tick_q == '0);
    assign at_dec = tick && (s_q == S_HI);
    assign at_end = tick && (s_q == S_END);
    assign vote   = majority3(samp_q[0], samp_q[1], rxs);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick ? TICK_LD : tick_q - 1'b1;
        s_d         = s_q;
        if (tick) s_d = (s_q == S_END) ? '0 : s_q + 1'b1;
        bit_d       = bit_q;
        samp_d      = samp_q;
        if (tick && (s_q == S_LO))  samp_d[0] = rxs;
        if (tick && (s_q == S_MID)) samp_d[1] = rxs;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    tick_d  = TICK_LD;
                    s_d     = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (at_dec && vote) state_d = IDLE;
                else if (at_end)    state_d = DATA;
            end
            DATA: begin
                if (at_dec) shift_d = DATA_WIDTH'({vote, shift_q} >> 1);
                if (at_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_dec) par_d = vote;
                if (at_end) state_d = STOP;
            end
`endif
            STOP: begin
                // Deciding mid-stop leaves time to catch a back-to-back start edge.
                if (at_dec) begin
                    if (vote) begin
                        push    = 1'b1;
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = (^shift_q) ^ par_q;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop       = !fifo_empty && rx_if.ready_i;
    assign overrun_d = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            s_q         <= '0;
            bit_q       <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            s_q         <= s_d;
            bit_q       <= bit_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    uart_rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rx_if.data_o  = fifo_data;
    assign rx_if.valid_o = !fifo_empty;
endmodule
